// File: rtl/wordline_pkg.sv
// ---------------------------------------------------------------------------
// wordline_pkg
//   Shared constants and types for the wordline decoder/encoder pair.
//   Used by the 6-to-64 wordline decoder and by wordline_encoder_64to6.
//
//   N_LINES   : number of wordlines (64 only)
//   IDX_W     : index width, log2(N_LINES)
//   GROUP_W   : wordlines per first-level priority group
//   N_GROUPS  : number of first-level groups
//   GRP_IDX_W : index width inside one group
// ---------------------------------------------------------------------------
package wordline_pkg;

    localparam int N_LINES   = 64;
    localparam int IDX_W     = 6;
    localparam int GROUP_W   = 8;
    localparam int N_GROUPS  = N_LINES / GROUP_W;
    localparam int GRP_IDX_W = 3;

    typedef logic [N_LINES-1:0]   wl_t;
    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [GRP_IDX_W-1:0] grp_idx_t;

endpackage : wordline_pkg

// File: rtl/encoder_8to3.sv
// ---------------------------------------------------------------------------
// encoder_8to3
//   Combinational 8-to-3 priority encoder, lowest set bit wins.
//
//   Ports:
//     lines  in   8  input lines; bit i asserted => candidate index i
//     idx    out  3  index of the lowest set bit (0 when no bit is set)
//     any    out  1  at least one line set
//     multi  out  1  more than one line set
// ---------------------------------------------------------------------------
module encoder_8to3
    import wordline_pkg::*;
(
    input  logic [GROUP_W-1:0]   lines,
    output logic [GRP_IDX_W-1:0] idx,
    output logic                 any,
    output logic                 multi
);

    // Scanning from the top down lets the lowest set bit overwrite any
    // higher one, which gives lowest-index priority without a chain of ifs.
    always_comb begin
        idx = '0;
        for (int i = GROUP_W - 1; i >= 0; i--) begin
            if (lines[i]) begin
                idx = GRP_IDX_W'(i);
            end
        end
    end

    assign any   = |lines;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(lines & (lines - GROUP_W'(1)));

endmodule : encoder_8to3

// File: rtl/wordline_encoder_64to6.sv
// ---------------------------------------------------------------------------
// wordline_encoder_64to6
//   Two-stage pipelined 64-to-6 priority encoder (lowest index wins), the
//   inverse of the 6-to-64 wordline decoder. Valid/ready on both sides with
//   per-stage bubble collapse; one result per cycle, two-cycle latency.
//
//   Stage 1 splits the word into 8 groups of 8 lines and records, per group,
//   whether any line is set and the lowest set line. Stage 2 picks the lowest
//   hitting group and concatenates {group, line-in-group}.
//
//   Ports:
//     clk        in   1   clock, rising edge
//     rst_n      in   1   asynchronous active-low reset
//     in_valid   in   1   wordline valid this cycle
//     in_ready   out  1   block accepts wordline this cycle
//     wordline   in   64  input lines; bit i asserted => index i
//     out_valid  out  1   index/hit/multi_hit valid
//     out_ready  in   1   consumer accepts result this cycle
//     index      out  6   lowest set bit (0 when hit=0)
//     hit        out  1   at least one wordline bit set
//     multi_hit  out  1   more than one bit set (only with ONEHOT_CHECK_EN)
//
//   Configuration macro:
//     ONEHOT_CHECK_EN  when defined, per-group multi flags are registered and
//                      multi_hit reports any word with more than one bit set;
//                      when undefined, multi_hit is constant 0.
// ---------------------------------------------------------------------------
module wordline_encoder_64to6
    import wordline_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_LINES-1:0] wordline,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   index,
    output logic               hit,
    output logic               multi_hit
);

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic vld_p1;
    logic vld_p2;
    logic load_p2;
    logic adv_p1;
    logic in_xfer;

    assign load_p2  = !vld_p2 || out_ready;
    assign adv_p1   = vld_p1 && load_p2;
    assign in_ready = !vld_p1 || adv_p1;
    assign in_xfer  = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 0 -> 1 : per-group encode of the incoming word
    // ------------------------------------------------------------------
    logic [N_GROUPS-1:0]                 grp_hit_c;
    logic [N_GROUPS-1:0][GRP_IDX_W-1:0]  grp_idx_c;
    logic [N_GROUPS-1:0]                 grp_multi_c;

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
        encoder_8to3 u_grp_enc (
            .lines (wordline[g*GROUP_W +: GROUP_W]),
            .idx   (grp_idx_c[g]),
            .any   (grp_hit_c[g]),
            .multi (grp_multi_c[g])
        );
    end

    logic [N_GROUPS-1:0]                 grp_hit_p1;
    logic [N_GROUPS-1:0][GRP_IDX_W-1:0]  grp_idx_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_xfer) begin
            vld_p1 <= 1'b1;
        end else if (adv_p1) begin
            vld_p1 <= 1'b0;
        end
    end

    // Group data only matters while vld_p1 is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            grp_hit_p1 <= grp_hit_c;
            grp_idx_p1 <= grp_idx_c;
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic [N_GROUPS-1:0] grp_multi_p1;

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            grp_multi_p1 <= grp_multi_c;
        end
    end
`else
    logic unused_grp_multi;
    assign unused_grp_multi = ^grp_multi_c;
`endif

    // ------------------------------------------------------------------
    // Stage 1 -> 2 : select lowest hitting group, build final index
    // ------------------------------------------------------------------
    grp_idx_t sel_grp_c;
    logic     any_grp_c;
    logic     multi_grp_c;

    encoder_8to3 u_sel_enc (
        .lines (grp_hit_p1),
        .idx   (sel_grp_c),
        .any   (any_grp_c),
        .multi (multi_grp_c)
    );

    idx_t index_c;
    logic multi_c;

    // The mask keeps a no-hit word at index 0 regardless of group contents.
    assign index_c = any_grp_c ? {sel_grp_c, grp_idx_p1[sel_grp_c]} : '0;

`ifdef ONEHOT_CHECK_EN
    // Multiple hits either inside one group or across two or more groups.
    assign multi_c = (|grp_multi_p1) || multi_grp_c;
`else
    assign multi_c = 1'b0;

    logic unused_multi_grp;
    assign unused_multi_grp = multi_grp_c;
`endif

    idx_t index_p2;
    logic hit_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
        end
    end

    // Outputs are visible to the consumer, so they are cleared on reset and
    // only change when a new result moves in; a stall leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_p2 <= '0;
            hit_p2   <= 1'b0;
        end else if (adv_p1) begin
            index_p2 <= index_c;
            hit_p2   <= any_grp_c;
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic multi_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_p2 <= 1'b0;
        end else if (adv_p1) begin
            multi_p2 <= multi_c;
        end
    end

    assign multi_hit = multi_p2;
`else
    logic unused_multi_c;
    assign unused_multi_c = multi_c;

    assign multi_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 2 : outputs
    // ------------------------------------------------------------------
    assign out_valid = vld_p2;
    assign index     = index_p2;
    assign hit       = hit_p2;

endmodule : wordline_encoder_64to6

// File: tb/tb_wordline_encoder_64to6.sv
// ---------------------------------------------------------------------------
// tb_wordline_encoder_64to6
//   Scoreboard bench: the driver pushes the expected result of every accepted
//   word into a queue; an independent monitor pops and compares whenever the
//   DUT hands over a result, and checks that stalled outputs do not move.
// ---------------------------------------------------------------------------
module tb_wordline_encoder_64to6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] wordline;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  index;
    logic        hit;
    logic        multi_hit;

    wordline_encoder_64to6 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wordline  (wordline),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .index     (index),
        .hit       (hit),
        .multi_hit (multi_hit)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int pop_count = 0;

    typedef struct packed {
        logic [63:0] w;
        logic [5:0]  idx;
        logic        hit;
        logic        multi;
    } exp_t;

    exp_t sb[$];

    // Reference: first set bit counting up from 0, hit if any bit, multi if
    // the population count exceeds one.
    function automatic exp_t model(input logic [63:0] w);
        exp_t e;
        bit   found;
        e.w     = w;
        e.idx   = 6'd0;
        e.hit   = (w != 64'd0);
        found   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!found && w[i]) begin
                e.idx = 6'(i);
                found = 1'b1;
            end
        end
`ifdef ONEHOT_CHECK_EN
        e.multi = ($countones(w) > 1);
`else
        e.multi = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t       mon_e;
    bit         held_vld = 1'b0;
    logic [5:0] held_idx;
    logic       held_hit;
    logic       held_multi;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held_vld) begin
                check("hold_index", 64'(index), 64'(held_idx));
                check("hold_hit", 64'(hit), 64'(held_hit));
                check("hold_multi", 64'(multi_hit), 64'(held_multi));
            end
            if (out_ready) begin
                held_vld = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got index %0d with empty scoreboard at %0t", index, $time);
                end else begin
                    mon_e = sb.pop_front();
                    pop_count++;
                    check("index", 64'(index), 64'(mon_e.idx));
                    check("hit", 64'(hit), 64'(mon_e.hit));
                    check("multi_hit", 64'(multi_hit), 64'(mon_e.multi));
                end
            end else begin
                held_vld   = 1'b1;
                held_idx   = index;
                held_hit   = hit;
                held_multi = multi_hit;
            end
        end else begin
            held_vld = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic send_word(input logic [63:0] w);
        int waits = 0;
        bit done  = 1'b0;
        in_valid = 1'b1;
        wordline = w;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(w));
                done = 1'b1;
            end else if (++waits > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        case ($urandom_range(0, 4))
            0: w = 64'd0;
            1: w = 64'd1 << $urandom_range(0, 63);
            2: w = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
            3: w = {$urandom, $urandom};
            default: w = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int base;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wordline  = 64'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_index", 64'(index), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_multi_hit", 64'(multi_hit), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Two-cycle latency on a single word
        send_word(64'h0000_0000_0000_0001);
        in_valid = 1'b0;
        check("latency_c1_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_c2_out_valid", 64'(out_valid), 64'd1);
        idle(2);

        // Top bit, empty word, two-bit word
        send_word(64'h8000_0000_0000_0000);
        send_word(64'h0000_0000_0000_0000);
        send_word(64'h0000_0100_0000_0010);
        idle(4);

        // Back-to-back one-hot stream
        base = pop_count;
        for (int i = 0; i < 64; i++) begin
            send_word(64'd1 << i);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("stream_results_no_bubbles", 64'(pop_count - base), 64'd64);

        // Five-cycle output stall with three words offered
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send_word(64'h0000_0000_00F0_0000);
                send_word(64'h0010_0000_0000_0000);
                send_word(64'h0000_0000_0000_0300);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check("stall_in_ready_low", 64'(in_ready), 64'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);
        check("stall_all_delivered", 64'(sb.size()), 64'd0);

        // Reset with two words in flight
        out_ready = 1'b0;
        send_word(64'h0000_0000_0000_0080);
        send_word(64'h0000_4000_0000_0000);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_index", 64'(index), 64'd0);
        check("midrst_hit", 64'(hit), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(8);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Randomized traffic with random backpressure
        repeat (600) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            wordline  = rand_word();
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(model(wordline));
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        check("final_drain_empty", 64'(sb.size()), 64'd0);
        check("final_out_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wordline_encoder_64to6
